alu_arbiter: RTL and testbench

//  Shares one registered 16-bit ALU (one-hot 5-bit opcode, 1-cycle latency, reset clears result)

---
 rtl/alu_arbiter_pkg.sv | 23 ++
 rtl/alu_arbiter_alu.sv | 42 ++++
 rtl/alu_arbiter_rr_pick.sv | 31 +++
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: data width, one-hot opcode
// encodings understood by the ALU, and the lock FSM state type.
package alu_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 5;

    // One-hot opcodes; anything that is not exactly one of these makes the
    // ALU pass operand B through, which is also what the idle opcode relies on.
    localparam logic [OP_W-1:0] OP_ADDAB = 5'b00001;
    localparam logic [OP_W-1:0] OP_XORAB = 5'b00010;
    localparam logic [OP_W-1:0] OP_ORAB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_NOTAB = 5'b01000;
    localparam logic [OP_W-1:0] OP_ANDAB = 5'b10000;
    localparam logic [OP_W-1:0] OP_NONE  = 5'b00000;

    // The lock owner itself lives in a separate register next to the state.
    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lockState_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Registered 16-bit ALU with one-hot opcode and one cycle of latency.
// Reset clears the result register.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o
);

    logic [DATA_W-1:0] result_d;
    logic [DATA_W-1:0] result_q;

    // Combinational operation select; NOTAB is the one's complement of A, and
    // zero or multi-hot opcodes fall through to operand B.
    always_comb begin
        result_d = b_i;
        case (op_i)
            OP_ADDAB: result_d = a_i + b_i;
            OP_XORAB: result_d = a_i ^ b_i;
            OP_ORAB:  result_d = a_i | b_i;
            OP_NOTAB: result_d = ~a_i;
            OP_ANDAB: result_d = a_i & b_i;
            default:  result_d = b_i;
        endcase
    end

    // Result register, cleared on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Rotate-priority one-hot picker: the search starts one past the pointer
// and wraps, so the requester at the pointer has the lowest priority.
module alu_arbiter_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    grant_o
);

    logic [N-1:0] grantD;
    logic         found;

    // Walk the offsets 1..N from the pointer and take the first requester seen.
    always_comb begin
        grantD = '0;
        found  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req_i[i] && (i == ((int'(ptr_i) + k) % N))) begin
                    grantD[i] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
    end

    assign grant_o = grantD;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between NUM_REQ requesters. Round-robin grant,
// optional lock so one requester can issue back-to-back, and result
// forwarding as operand A when the same requester chains consecutive ops.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      iClock,
    input  logic                      iReset,
    input  logic [NUM_REQ-1:0]        iReqValid,
    input  logic [NUM_REQ-1:0]        iReqLock,
    input  logic [NUM_REQ-1:0]        iReqChain,
    input  logic [OP_W*NUM_REQ-1:0]   iReqOp,
    input  logic [DATA_W*NUM_REQ-1:0] iReqOpA,
    input  logic [DATA_W*NUM_REQ-1:0] iReqOpB,
    output logic [NUM_REQ-1:0]        oReqReady,
    output logic [NUM_REQ-1:0]        oRspValid,
    output logic [ID_W-1:0]           oRspId,
    output logic [DATA_W-1:0]         oRspData
);

    lockState_t        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   lastGrant_q, lastGrant_d;
    logic              rspValid_q;
    logic [ID_W-1:0]   rspId_q;

    logic [NUM_REQ-1:0] rrGrant;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grantIdx;
    logic               accept;
    logic               chainOk;
    logic [OP_W-1:0]    aluOp;
    logic [DATA_W-1:0]  aluA;
    logic [DATA_W-1:0]  aluB;
    logic [DATA_W-1:0]  aluResult;
    logic [NUM_REQ-1:0] rspVec;

    alu_arbiter_rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) uRrPick (
        .req_i   (iReqValid),
        .ptr_i   (lastGrant_q),
        .grant_o (rrGrant)
    );

    // Lock state, lock owner and round-robin pointer; reset points the
    // search just before requester 0 so it wins first.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q     <= ST_UNLOCKED;
            owner_q     <= '0;
            lastGrant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    // Next lock state: any accepted op re-arms or releases the lock from its
    // own iReqLock; a locked cycle with nothing accepted means the owner
    // dropped valid, which releases the lock and leaves the pointer on it.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastGrant_d = lastGrant_q;
        if (accept) begin
            lastGrant_d = grantIdx;
            owner_d     = grantIdx;
            state_d     = iReqLock[grantIdx] ? ST_LOCKED : ST_UNLOCKED;
        end else if (state_q == ST_LOCKED) begin
            state_d = ST_UNLOCKED;
        end
    end

    // Grant output: the lock owner alone while locked, otherwise the
    // round-robin pick; nothing is granted while reset is held.
    always_comb begin
        grant = '0;
        if (!iReset) begin
            if (state_q == ST_LOCKED) begin
                if (iReqValid[owner_q]) begin
                    grant[owner_q] = 1'b1;
                end
            end else begin
                grant = rrGrant;
            end
        end
    end

    // Encode the one-hot grant into a requester index.
    always_comb begin
        grantIdx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grantIdx = ID_W'(i);
            end
        end
    end

    assign accept = |grant;

    // Forwarding is only valid when the requester issued last cycle too, in
    // which case the ALU output still holds its previous result.
    assign chainOk = accept && rspValid_q && (rspId_q == grantIdx) && iReqChain[grantIdx];

    // Operand and opcode muxes into the ALU; idle cycles feed the
    // pass-through opcode with B=0 so the ALU register settles to zero.
    always_comb begin
        aluOp = OP_NONE;
        aluA  = '0;
        aluB  = '0;
        if (accept) begin
            aluOp = iReqOp[int'(grantIdx)*OP_W +: OP_W];
            aluB  = iReqOpB[int'(grantIdx)*DATA_W +: DATA_W];
            aluA  = chainOk ? aluResult : iReqOpA[int'(grantIdx)*DATA_W +: DATA_W];
        end
    end

    alu_arbiter_alu uAlu (
        .clk_i    (iClock),
        .rst_i    (iReset),
        .op_i     (aluOp),
        .a_i      (aluA),
        .b_i      (aluB),
        .result_o (aluResult)
    );

    // Response tag pipe, aligned with the ALU register so valid/id line up
    // with the result one cycle after issue.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            rspValid_q <= 1'b0;
            rspId_q    <= '0;
        end else begin
            rspValid_q <= accept;
            rspId_q    <= grantIdx;
        end
    end

    // One-hot response valid; a response that lands in a reset cycle is
    // dropped rather than delivered to its requester.
    always_comb begin
        rspVec = '0;
        if (rspValid_q && !iReset) begin
            rspVec[rspId_q] = 1'b1;
        end
    end

    assign oReqReady = grant;
    assign oRspValid = rspVec;
    assign oRspId    = iReset ? '0 : rspId_q;
    assign oRspData  = aluResult;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: the stimulus side checks grants and queues
// the expected response; a negedge monitor matches responses to the queue.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        iClock = 1'b0;
    logic        iReset;
    logic [3:0]  reqValid, reqLock, reqChain;
    logic [19:0] reqOp;
    logic [63:0] reqA, reqB;
    logic [3:0]  oReqReady, oRspValid;
    logic [1:0]  oRspId;
    logic [15:0] oRspData;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sbQ[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cycleCnt = 0;

    alu_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .iClock    (iClock),
        .iReset    (iReset),
        .iReqValid (reqValid),
        .iReqLock  (reqLock),
        .iReqChain (reqChain),
        .iReqOp    (reqOp),
        .iReqOpA   (reqA),
        .iReqOpB   (reqB),
        .oReqReady (oReqReady),
        .oRspValid (oRspValid),
        .oRspId    (oRspId),
        .oRspData  (oRspData)
    );

    always #5 iClock = ~iClock;

    always @(posedge iClock) cycleCnt <= cycleCnt + 1;

    function automatic logic [1:0] idxOf(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic setReq(input int i, input logic v, input logic l, input logic c,
                          input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        reqValid[i]       = v;
        reqLock[i]        = l;
        reqChain[i]       = c;
        reqOp[i*5 +: 5]   = op;
        reqA[i*16 +: 16]  = a;
        reqB[i*16 +: 16]  = b;
    endtask

    task automatic clearReqs();
        reqValid = '0;
        reqLock  = '0;
        reqChain = '0;
        reqOp    = '0;
        reqA     = '0;
        reqB     = '0;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    // Inputs are already driven; check the grant mid-cycle, queue the expected
    // response for the next cycle, then step to just after the next edge.
    task automatic applyStimulus(input logic [3:0] expReady, input logic [15:0] expData, input bit push);
        exp_t e;
        @(negedge iClock);
        checkOutput("grant", {12'b0, oReqReady}, {12'b0, expReady});
        if (push && expReady != 4'b0000) begin
            e.id   = idxOf(expReady);
            e.data = expData;
            e.due  = cycleCnt + 1;
            sbQ.push_back(e);
        end
        @(posedge iClock);
        #1;
    endtask

    // Response monitor: a queued entry due now must appear, and nothing may
    // appear that was not queued.
    always @(negedge iClock) begin : monitor
        exp_t e;
        if (sbQ.size() > 0 && sbQ[0].due == cycleCnt) begin
            e = sbQ.pop_front();
            checks++;
            if (oRspValid !== (4'b0001 << e.id) || oRspId !== e.id || oRspData !== e.data) begin
                errors++;
                $display("[TB] FAIL response: got valid=%b id=%0d data=%h, expected valid=%b id=%0d data=%h",
                         oRspValid, oRspId, oRspData, 4'b0001 << e.id, e.id, e.data);
            end
        end else if (oRspValid !== 4'b0000) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected response: got valid=%b id=%0d data=%h, expected valid=0000",
                     oRspValid, oRspId, oRspData);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        iReset = 1'b1;
        clearReqs();
        for (int i = 0; i < 4; i++) setReq(i, 1'b1, 1'b0, 1'b0, OP_ADDAB, 16'd1, 16'd1);

        // Reset state with every requester asking
        repeat (2) @(posedge iClock);
        @(negedge iClock);
        checkOutput("reset ready", {12'b0, oReqReady}, 16'h0000);
        checkOutput("reset rspValid", {12'b0, oRspValid}, 16'h0000);
        checkOutput("reset rspId", {14'b0, oRspId}, 16'h0000);
        checkOutput("reset rspData", oRspData, 16'h0000);
        @(posedge iClock);
        #1;
        iReset = 1'b0;

        // 1: round robin 0,1,2,3 with ADD 1+1
        applyStimulus(4'b0001, 16'd2, 1'b1);
        applyStimulus(4'b0010, 16'd2, 1'b1);
        applyStimulus(4'b0100, 16'd2, 1'b1);
        applyStimulus(4'b1000, 16'd2, 1'b1);
        clearReqs();
        applyStimulus(4'b0000, 16'd0, 1'b0);

        // 2: req1 locked chain while req2/req3 wait
        setReq(1, 1'b1, 1'b1, 1'b0, OP_ADDAB, 16'd5, 16'd3);
        setReq(2, 1'b1, 1'b0, 1'b0, OP_ORAB, 16'h00F0, 16'h000F);
        setReq(3, 1'b1, 1'b0, 1'b0, OP_ADDAB, 16'h0100, 16'h0023);
        applyStimulus(4'b0010, 16'd8, 1'b1);
        setReq(1, 1'b1, 1'b1, 1'b1, OP_ADDAB, 16'hDEAD, 16'd2);
        applyStimulus(4'b0010, 16'd10, 1'b1);
        setReq(1, 1'b1, 1'b0, 1'b1, OP_ANDAB, 16'hDEAD, 16'h000F);
        applyStimulus(4'b0010, 16'h000A, 1'b1);
        setReq(1, 1'b0, 1'b0, 1'b0, OP_NONE, 16'd0, 16'd0);
        applyStimulus(4'b0100, 16'h00FF, 1'b1);
        setReq(2, 1'b0, 1'b0, 1'b0, OP_NONE, 16'd0, 16'd0);
        // 3: req0 waits with chain set while req3 issues, then chain is ignored
        setReq(0, 1'b1, 1'b0, 1'b1, OP_XORAB, 16'h1234, 16'h00FF);
        applyStimulus(4'b1000, 16'h0123, 1'b1);
        setReq(3, 1'b0, 1'b0, 1'b0, OP_NONE, 16'd0, 16'd0);
        applyStimulus(4'b0001, 16'h12CB, 1'b1);
        clearReqs();
        applyStimulus(4'b0000, 16'd0, 1'b0);

        // 4: req2 locks then drops valid; lock clears and req3 is next
        setReq(2, 1'b1, 1'b1, 1'b0, OP_ADDAB, 16'h0010, 16'h0020);
        setReq(0, 1'b1, 1'b0, 1'b0, OP_ORAB, 16'h0005, 16'h000A);
        setReq(3, 1'b1, 1'b0, 1'b0, OP_ADDAB, 16'd3, 16'd4);
        applyStimulus(4'b0100, 16'h0030, 1'b1);
        setReq(2, 1'b0, 1'b0, 1'b0, OP_NONE, 16'd0, 16'd0);
        applyStimulus(4'b0000, 16'd0, 1'b0);
        applyStimulus(4'b1000, 16'd7, 1'b1);
        setReq(3, 1'b0, 1'b0, 1'b0, OP_NONE, 16'd0, 16'd0);
        applyStimulus(4'b0001, 16'h000F, 1'b1);
        clearReqs();
        applyStimulus(4'b0000, 16'd0, 1'b0);

        // 5: reset the cycle after req0 is granted; response discarded
        setReq(0, 1'b1, 1'b0, 1'b0, OP_ADDAB, 16'h0040, 16'h0002);
        applyStimulus(4'b0001, 16'h0042, 1'b0);
        iReset = 1'b1;
        clearReqs();
        @(negedge iClock);
        checkOutput("rspValid in reset cycle", {12'b0, oRspValid}, 16'h0000);
        @(posedge iClock);
        #1;
        @(negedge iClock);
        checkOutput("rspValid after reset", {12'b0, oRspValid}, 16'h0000);
        checkOutput("rspData after reset", oRspData, 16'h0000);
        @(posedge iClock);
        #1;
        iReset = 1'b0;
        for (int i = 0; i < 4; i++) setReq(i, 1'b1, 1'b0, 1'b0, OP_ADDAB, 16'd1, 16'd2);
        applyStimulus(4'b0001, 16'd3, 1'b1);
        clearReqs();
        applyStimulus(4'b0000, 16'd0, 1'b0);

        // 6: multi-hot opcode passes B, ADD wraps
        setReq(1, 1'b1, 1'b0, 1'b0, 5'b00011, 16'd7, 16'd9);
        setReq(2, 1'b1, 1'b0, 1'b0, OP_ADDAB, 16'hFFFF, 16'h0002);
        applyStimulus(4'b0010, 16'd9, 1'b1);
        setReq(1, 1'b0, 1'b0, 1'b0, OP_NONE, 16'd0, 16'd0);
        applyStimulus(4'b0100, 16'h0001, 1'b1);
        clearReqs();
        applyStimulus(4'b0000, 16'd0, 1'b0);
        applyStimulus(4'b0000, 16'd0, 1'b0);

        checkOutput("scoreboard drained", 16'(sbQ.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
